layer3_array_ctrl: RTL

Sequencer that drives the layer-3 binarized compute array: 32 ASM3 units arranged as 4 pixel lanes × 8 channels. It fetches pixel, weight and batch-norm words from single-cycle-latency memories and presents them to the array with the array's internal one-cycle weight/bn register accounted for. It generates the per-lane `calculate_en`, `asm_choose` and `asm_change` controls, and flags when the array's 32-bit `data_out` holds a finished group of results.

---
 rtl/layer3_array_ctrl.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/layer3_array_ctrl.sv
// Sequencer for the layer-3 binarized ASM3 array (4 pixel lanes x 8 channels).
// Optional feature macro: LAYER3_CTRL_STALL_EN adds a `hold` input that freezes issue.
module layer3_array_ctrl #(
  parameter int KERNEL_LEN = 9,
  parameter int NUM_OUT    = 64,
  parameter int PIX_AW     = 16,
  parameter int COEF_AW    = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
`ifdef LAYER3_CTRL_STALL_EN
  input  logic               hold,
`endif
  output logic               busy,
  output logic               done,
  output logic [PIX_AW-1:0]  pix_addr,
  input  logic [7:0]         pix_rdata,
  output logic [COEF_AW-1:0] coef_addr,
  input  logic [31:0]        w_rdata,
  input  logic [15:0]        bn_rdata,
  output logic [1:0]         data_pix1,
  output logic [1:0]         data_pix2,
  output logic [1:0]         data_pix3,
  output logic [1:0]         data_pix4,
  output logic [31:0]        data_weight,
  output logic [15:0]        data_bn,
  output logic [3:0]         calculate_en,
  output logic [31:0]        asm_choose,
  output logic [31:0]        asm_change,
  output logic               out_valid,
  output logic [11:0]        out_group
);

  localparam int                NUM_GROUPS = (NUM_OUT + 3) / 4;
  localparam logic [11:0]       K_LAST     = 12'(KERNEL_LEN - 1);
  localparam logic [11:0]       G_LAST     = 12'(NUM_GROUPS - 1);
  localparam logic [PIX_AW-1:0] K_STEP     = PIX_AW'(KERNEL_LEN);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

  state_t               state_r, state_s;
  logic [11:0]          k_r, k_s, g_r, g_s;
  logic [PIX_AW-1:0]    base_r, base_s, pix_addr_r, pix_addr_s;
  logic [COEF_AW-1:0]   coef_addr_r, coef_addr_s;
  logic                 bank_r, bank_s;
  logic                 hold_s, issue_s, step_last_s, group_last_s, final_valid_s;
  logic [3:0]           lane_mask_s;

  // Issue-side pipeline (stage 1 = t+1 ... stage 4 = t+4 relative to issue)
  logic                 v1_r, last1_r, bank1_r, last2_r, change_r, choose_r;
  logic [3:0]           mask1_r, cal_en_r;
  logic [11:0]          g1_r, g2_r, g3_r, out_group_r;
  logic [7:0]           pix_r;
  logic                 out_valid_r, done_r, busy_r;

`ifdef LAYER3_CTRL_STALL_EN
  assign hold_s = hold;
`else
  assign hold_s = 1'b0;
`endif

  assign issue_s       = (state_r == S_RUN) && !hold_s;
  assign step_last_s   = (k_r == K_LAST);
  assign group_last_s  = (g_r == G_LAST);
  assign final_valid_s = out_valid_r && (out_group_r == G_LAST);

  // Lane l of group g is live only while 4g+l still addresses a real output
  always_comb begin
    lane_mask_s = 4'd0;
    for (int l = 0; l < 4; l++) begin
      if (({18'd0, g_r, 2'b00} + 32'(l)) < 32'(NUM_OUT)) lane_mask_s[l] = 1'b1;
      else lane_mask_s[l] = 1'b0;
    end
  end

  // Next-state, counter and address computation
  always_comb begin
    state_s     = state_r;
    k_s         = k_r;
    g_s         = g_r;
    base_s      = base_r;
    bank_s      = bank_r;
    pix_addr_s  = pix_addr_r;
    coef_addr_s = coef_addr_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_s = S_RUN;
        else state_s = S_IDLE;
        k_s         = 12'd0;
        g_s         = 12'd0;
        base_s      = {PIX_AW{1'b0}};
        bank_s      = 1'b0;
        pix_addr_s  = {PIX_AW{1'b0}};
        coef_addr_s = {COEF_AW{1'b0}};
      end
      S_RUN: begin
        if (hold_s) begin
          state_s = S_RUN;
        end else if (step_last_s && group_last_s) begin
          state_s     = S_DRAIN;
          k_s         = 12'd0;
          g_s         = 12'd0;
          base_s      = {PIX_AW{1'b0}};
          bank_s      = 1'b0;
          pix_addr_s  = {PIX_AW{1'b0}};
          coef_addr_s = {COEF_AW{1'b0}};
        end else if (step_last_s) begin
          // Running base avoids a g*KERNEL_LEN multiplier
          k_s         = 12'd0;
          g_s         = g_r + 12'd1;
          base_s      = base_r + K_STEP;
          bank_s      = ~bank_r;
          pix_addr_s  = base_r + K_STEP;
          coef_addr_s = {COEF_AW{1'b0}};
        end else begin
          k_s         = k_r + 12'd1;
          pix_addr_s  = pix_addr_r + PIX_AW'(1);
          coef_addr_s = COEF_AW'(k_r + 12'd1);
        end
      end
      S_DRAIN: begin
        if (final_valid_s) state_s = S_FIN;
        else state_s = S_DRAIN;
      end
      S_FIN:   state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // FSM, counters and issued addresses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= S_IDLE;
      k_r         <= 12'd0;
      g_r         <= 12'd0;
      base_r      <= {PIX_AW{1'b0}};
      bank_r      <= 1'b0;
      pix_addr_r  <= {PIX_AW{1'b0}};
      coef_addr_r <= {COEF_AW{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      k_r         <= k_s;
      g_r         <= g_s;
      base_r      <= base_s;
      bank_r      <= bank_s;
      pix_addr_r  <= pix_addr_s;
      coef_addr_r <= coef_addr_s;
      busy_r      <= (state_s != S_IDLE);
      done_r      <= (state_r == S_DRAIN) && final_valid_s;
    end
  end

  // Control pipeline aligned to memory latency and the array's weight register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_r        <= 1'b0;
      last1_r     <= 1'b0;
      bank1_r     <= 1'b0;
      mask1_r     <= 4'd0;
      g1_r        <= 12'd0;
      cal_en_r    <= 4'd0;
      pix_r       <= 8'd0;
      last2_r     <= 1'b0;
      g2_r        <= 12'd0;
      choose_r    <= 1'b0;
      change_r    <= 1'b0;
      g3_r        <= 12'd0;
      out_valid_r <= 1'b0;
      out_group_r <= 12'd0;
    end else begin
      v1_r        <= issue_s;
      last1_r     <= issue_s && step_last_s;
      bank1_r     <= bank_r;
      mask1_r     <= lane_mask_s;
      g1_r        <= g_r;
      cal_en_r    <= v1_r ? mask1_r : 4'd0;
      pix_r       <= v1_r ? pix_rdata : 8'd0;
      last2_r     <= v1_r && last1_r;
      g2_r        <= g1_r;
      // The finishing group's bank must stay selected through its asm_change
      if (last2_r) choose_r <= choose_r;
      else if (v1_r) choose_r <= bank1_r;
      else if (state_s == S_IDLE) choose_r <= 1'b0;
      else choose_r <= choose_r;
      change_r    <= last2_r;
      g3_r        <= g2_r;
      out_valid_r <= change_r;
      out_group_r <= g3_r;
    end
  end

  assign busy         = busy_r;
  assign done         = done_r;
  assign pix_addr     = pix_addr_r;
  assign coef_addr    = coef_addr_r;
  assign data_pix1    = pix_r[1:0];
  assign data_pix2    = pix_r[3:2];
  assign data_pix3    = pix_r[5:4];
  assign data_pix4    = pix_r[7:6];
  assign data_weight  = w_rdata;
  assign data_bn      = bn_rdata;
  assign calculate_en = cal_en_r;
  assign asm_choose   = {32{choose_r}};
  assign asm_change   = {32{change_r}};
  assign out_valid    = out_valid_r;
  assign out_group    = out_group_r;

endmodule
